// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with configurable data width, parity and stop bits,
// a two-flop input synchroniser, start-glitch rejection, and parity/framing/break flags.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_RX_Serial,
    output logic                 o_DV,
    output logic [DATA_BITS-1:0] o_RX_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

    state_t               state;
    logic                 rx_meta, rx_sync;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] sh;
    logic                 par_bit, fe_acc, stop_idx;
    logic                 fe_now, par_err_now, brk_now, last_stop;

    // Preset to idle-high so reset release never looks like a start bit.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_sync <= rx_meta;
        end
    end

    // Earlier stop samples only count once the second stop bit is being taken.
    assign last_stop   = stop_idx == 1'(STOP_BITS - 1);
    assign fe_now      = ~rx_sync | (stop_idx & fe_acc);
    assign par_err_now = (PARITY != 0) & ((^{sh, par_bit}) ^ (PARITY == 1));
    assign brk_now     = (sh == '0) & ~par_bit & fe_now;
    assign o_Busy      = state != S_IDLE;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            sh           <= '0;
            par_bit      <= 1'b0;
            fe_acc       <= 1'b0;
            stop_idx     <= 1'b0;
            o_DV         <= 1'b0;
            o_RX_Data    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
        end else begin
            o_DV <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    par_bit  <= 1'b0;
                    if (!rx_sync) state <= S_START;
                end
                S_START: begin
                    if (cnt == MID) begin
                        cnt   <= '0;
                        state <= rx_sync ? S_IDLE : S_DATA;
                    end else cnt <= cnt + 1'b1;
                end
                S_DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        sh      <= {rx_sync, sh[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 4'(DATA_BITS - 1)) state <= (PARITY != 0) ? S_PAR : S_STOP;
                    end else cnt <= cnt + 1'b1;
                end
                S_PAR: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        par_bit <= rx_sync;
                        state   <= S_STOP;
                    end else cnt <= cnt + 1'b1;
                end
                S_STOP: begin
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        fe_acc   <= ~rx_sync;
                        stop_idx <= 1'b1;
                        if (last_stop) begin
                            o_DV         <= 1'b1;
                            o_RX_Data    <= sh;
                            o_Parity_Err <= par_err_now;
                            o_Frame_Err  <= fe_now;
                            o_Break      <= brk_now;
                            state        <= brk_now ? S_BRK : S_IDLE;
                        end
                    end else cnt <= cnt + 1'b1;
                end
                S_BRK: if (rx_sync) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed checks of uart_rx_cfg in 8N1, 7E1 and 8N2 configurations.
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx1 = 1'b1, rx2 = 1'b1, rx3 = 1'b1;
    logic dv1, dv2, dv3, pe1, pe2, pe3, fe1, fe2, fe3, bk1, bk2, bk3, busy1, busy2, busy3;
    logic [7:0] d1, d3;
    logic [6:0] d2;
    int n_cmp = 0, n_err = 0;
    int dvc1 = 0, dvc2 = 0, dvc3 = 0;
    logic [7:0] cap1 = '0, prev1 = '0, cap3 = '0;
    logic [6:0] cap2 = '0;
    logic cpe1, cfe1, cbk1, cpe2, cfe2, cbk2, cpe3, cfe3, cbk3;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx1), .o_DV(dv1), .o_RX_Data(d1),
        .o_Parity_Err(pe1), .o_Frame_Err(fe1), .o_Break(bk1), .o_Busy(busy1));
    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx2), .o_DV(dv2), .o_RX_Data(d2),
        .o_Parity_Err(pe2), .o_Frame_Err(fe2), .o_Break(bk2), .o_Busy(busy2));
    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx3), .o_DV(dv3), .o_RX_Data(d3),
        .o_Parity_Err(pe3), .o_Frame_Err(fe3), .o_Break(bk3), .o_Busy(busy3));

    always @(negedge clk) if (dv1) begin
        dvc1++; prev1 = cap1; cap1 = d1; cpe1 = pe1; cfe1 = fe1; cbk1 = bk1;
    end
    always @(negedge clk) if (dv2) begin
        dvc2++; cap2 = d2; cpe2 = pe2; cfe2 = fe2; cbk2 = bk2;
    end
    always @(negedge clk) if (dv3) begin
        dvc3++; cap3 = d3; cpe3 = pe3; cfe3 = fe3; cbk3 = bk3;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int ln, input logic v);
        if (ln == 1) rx1 = v;
        else if (ln == 2) rx2 = v;
        else rx3 = v;
    endtask

    task automatic send(input int ln, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            drive(ln, bits[i]);
            repeat (16) @(negedge clk);
        end
        drive(ln, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] f8n1(input logic [7:0] b);
        return {6'b0, 1'b1, b, 1'b0};
    endfunction

    initial begin
        int c;
        logic [15:0] v;
        idle(3);
        check("rst_dv", dv1, 0);
        check("rst_data", d1, 0);
        check("rst_flags", {pe1, fe1, bk1}, 0);
        check("rst_busy", busy1, 0);
        rst_n = 1'b1;
        idle(20);

        v = f8n1(8'h37);
        for (int i = 0; i < 9; i++) begin
            rx1 = v[i];
            idle(16);
        end
        rx1 = 1'b1;
        idle(14);
        check("t1_busy_mid_stop", busy1, 0);
        check("t1_dvcount", dvc1, 1);
        check("t1_data", cap1, 8'h37);
        check("t1_flags", {cpe1, cfe1, cbk1}, 0);
        idle(20);

        send(2, {6'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10);
        idle(16);
        check("t2_dvcount", dvc2, 1);
        check("t2_data", cap2, 7'h41);
        check("t2_perr", cpe2, 0);
        send(2, {6'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
        idle(16);
        check("t2b_dvcount", dvc2, 2);
        check("t2b_data", cap2, 7'h41);
        check("t2b_perr", cpe2, 1);
        check("t2b_ferr", cfe2, 0);

        send(3, {5'b0, 1'b0, 1'b1, 8'hA5, 1'b0}, 11);
        idle(48);
        check("t3_dvcount", dvc3, 1);
        check("t3_data", cap3, 8'hA5);
        check("t3_ferr", cfe3, 1);
        check("t3_brk", cbk3, 0);
        send(3, {5'b0, 2'b11, 8'h5A, 1'b0}, 11);
        idle(16);
        check("t3b_dvcount", dvc3, 2);
        check("t3b_data", cap3, 8'h5A);
        check("t3b_ferr", cfe3, 0);

        c = dvc1;
        rx1 = 1'b0;
        idle(480);
        check("t4_dvcount", dvc1, c + 1);
        check("t4_data", cap1, 0);
        check("t4_ferr_brk", {cfe1, cbk1}, 2'b11);
        rx1 = 1'b1;
        idle(32);
        send(1, f8n1(8'hC3), 10);
        idle(16);
        check("t4b_dvcount", dvc1, c + 2);
        check("t4b_data", cap1, 8'hC3);
        check("t4b_flags", {cpe1, cfe1, cbk1}, 0);

        c = dvc1;
        rx1 = 1'b0;
        idle(4);
        rx1 = 1'b1;
        for (int i = 0; i < 10 && busy1; i++) @(negedge clk);
        check("t5_busy", busy1, 0);
        idle(40);
        check("t5_dvcount", dvc1, c);
        check("t5_outputs", {d1, pe1, fe1, bk1}, {8'hC3, 3'b000});

        c = dvc1;
        rx1 = 1'b0;
        idle(16);
        rx1 = 1'b1;
        idle(56);
        check("t6_busy_before", busy1, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy1, 0);
        check("t6_rst_data", d1, 0);
        check("t6_rst_flags", {dv1, pe1, fe1, bk1}, 0);
        idle(5);
        rst_n = 1'b1;
        idle(200);
        check("t6_no_dv", dvc1, c);
        send(1, f8n1(8'h81), 10);
        idle(16);
        check("t6_dvcount", dvc1, c + 1);
        check("t6_data", cap1, 8'h81);
        send(1, f8n1(8'h11), 10);
        send(1, f8n1(8'h22), 10);
        idle(16);
        check("t6b_dvcount", dvc1, c + 3);
        check("t6b_first", prev1, 8'h11);
        check("t6b_second", cap1, 8'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
